// File: rtl/tm1637_display_ctrl.sv
// TM1637 frame sequencer: snapshots four hex digits, dp and brightness,
// then issues the 7-byte display update through the byte driver handshake.
module tm1637_display_ctrl #(
   parameter int unsigned REFRESH_CYCLES = 0,
   parameter int unsigned CNT_W          = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp,
   input  logic [2:0]  brightness,
   input  logic        display_on,
   input  logic        update,
   output logic        ready,
   output logic        drv_latch,
   output logic [7:0]  drv_byte,
   output logic        drv_stop,
   input  logic        drv_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_HOLD,
      S_WAIT,
      S_NEXT
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [2:0]  idx;
   logic [15:0] dig_q;
   logic [3:0]  dp_q;
   logic [2:0]  br_q;
   logic        on_q;
   logic        pending;
   logic        tick;
   logic [8:0]  cur;
   logic [8:0]  hold_q;

   function automatic logic [6:0] seg(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Auto refresh counts idle cycles only and restarts on every sequence
   if (REFRESH_CYCLES > 0) begin : g_refresh
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
         if (rst || state_nx == S_LOAD) begin
            cnt <= '0;
         end else if (state == S_IDLE) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign tick = (state == S_IDLE) &&
                    (cnt == CNT_W'(REFRESH_CYCLES - 1));
   end else begin : g_no_refresh
      assign tick = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (update || pending || tick) state_nx = S_LOAD;
         S_LOAD: state_nx = S_SEND;
         S_SEND: state_nx = S_HOLD;
         S_HOLD: state_nx = S_WAIT;
         S_WAIT: if (!drv_busy) state_nx = S_NEXT;
         S_NEXT: state_nx = (idx == 3'd6) ? S_IDLE : S_SEND;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         dig_q   <= '0;
         dp_q    <= '0;
         br_q    <= '0;
         on_q    <= 1'b0;
         pending <= 1'b0;
         hold_q  <= '0;
      end else begin
         if (state == S_IDLE) begin
            pending <= 1'b0;
         end else if (update) begin
            pending <= 1'b1;
         end
         if (state == S_LOAD) begin
            idx   <= '0;
            dig_q <= digits;
            dp_q  <= dp;
            br_q  <= brightness;
            on_q  <= display_on;
         end
         if (state == S_NEXT && idx != 3'd6) begin
            idx <= idx + 3'd1;
         end
         if (state == S_SEND) begin
            hold_q <= cur;
         end
      end
   end

   // cur = {stop, byte} for the current index
   always_comb begin
      cur = 9'h000;
      unique case (idx)
         3'd0: cur = {1'b1, 8'h40};
         3'd1: cur = {1'b0, 8'hC0};
         3'd2: cur = {1'b0, dp_q[3], seg(dig_q[15:12])};
         3'd3: cur = {1'b0, dp_q[2], seg(dig_q[11:8])};
         3'd4: cur = {1'b0, dp_q[1], seg(dig_q[7:4])};
         3'd5: cur = {1'b1, dp_q[0], seg(dig_q[3:0])};
         3'd6: cur = on_q ? {1'b1, 5'b10001, br_q}
                          : {1'b1, 8'h80};
         default: cur = 9'h000;
      endcase
   end

   always_comb begin
      ready     = (state == S_IDLE) && !pending;
      drv_latch = (state == S_SEND);
      {drv_stop, drv_byte} = (state == S_SEND) ? cur : hold_q;
   end

endmodule

// File: tb/tb_tm1637_display_ctrl.sv
// Bench for tm1637_display_ctrl: byte-level driver model plus
// reference byte model derived from the TM1637 frame format.
module tb_tm1637_display_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [15:0] digits = '0;
   logic [3:0]  dp = '0;
   logic [2:0]  brightness = '0;
   logic        display_on = 1'b0;
   logic        update = 1'b0;
   logic        ready;
   logic        drv_latch;
   logic [7:0]  drv_byte;
   logic        drv_stop;
   logic        drv_busy;

   logic        rst_r = 1'b1;
   logic        ready_r;
   logic        latch_r;
   logic [7:0]  byte_r;
   logic        stop_r;
   logic        busy_r;

   tm1637_display_ctrl #(.REFRESH_CYCLES(0), .CNT_W(24)) dut (
      .clk(clk), .rst(rst), .digits(digits), .dp(dp),
      .brightness(brightness), .display_on(display_on),
      .update(update), .ready(ready), .drv_latch(drv_latch),
      .drv_byte(drv_byte), .drv_stop(drv_stop), .drv_busy(drv_busy)
   );

   tm1637_display_ctrl #(.REFRESH_CYCLES(100), .CNT_W(8)) dut_r (
      .clk(clk), .rst(rst_r), .digits(16'h0F5A), .dp(4'b0101),
      .brightness(3'd3), .display_on(1'b1),
      .update(1'b0), .ready(ready_r), .drv_latch(latch_r),
      .drv_byte(byte_r), .drv_stop(stop_r), .drv_busy(busy_r)
   );

   int n_assert = 0;
   int n_fail = 0;

   logic [6:0] seg_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Driver models: busy rises the cycle after a latch
   int busy_len = 20;
   int bcnt;
   int bcnt_r;
   always @(posedge clk) begin
      if (rst) bcnt <= 0;
      else if (drv_latch) bcnt <= busy_len;
      else if (bcnt != 0) bcnt <= bcnt - 1;
      if (rst_r) bcnt_r <= 0;
      else if (latch_r) bcnt_r <= 5;
      else if (bcnt_r != 0) bcnt_r <= bcnt_r - 1;
   end
   assign drv_busy = (bcnt != 0);
   assign busy_r = (bcnt_r != 0);

   logic [8:0] got[$];
   logic [8:0] got_r[$];
   logic [8:0] last;
   int hold_err = 0;
   int run = 0;
   int runs[$];

   always @(negedge clk) begin
      if (rst) begin
         last <= '0;
      end else if (drv_latch) begin
         got.push_back({drv_stop, drv_byte});
         last <= {drv_stop, drv_byte};
      end else if ({drv_stop, drv_byte} !== last) begin
         hold_err <= hold_err + 1;
      end
      if (rst_r) begin
         run <= 0;
      end else begin
         if (latch_r) got_r.push_back({stop_r, byte_r});
         if (ready_r) run <= run + 1;
         else if (run != 0) begin
            runs.push_back(run);
            run <= 0;
         end
      end
   end

   function automatic logic [8:0] ref_byte(input int i,
         input logic [15:0] d, input logic [3:0] p,
         input logic [2:0] b, input logic o);
      logic [3:0] nib;
      if (i == 0) return {1'b1, 8'h40};
      if (i == 1) return {1'b0, 8'hC0};
      if (i == 6) return {1'b1, o ? (8'h88 | {5'd0, b}) : 8'h80};
      nib = d[4*(5-i) +: 4];
      return {i == 5, p[5-i], seg_tab[nib]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_seq(input string tag, input int base,
         input logic [15:0] d, input logic [3:0] p,
         input logic [2:0] b, input logic o);
      logic [8:0] obs;
      for (int i = 0; i < 7; i++) begin
         obs = (base + i < got.size()) ? got[base + i] : 9'h1FF;
         chk($sformatf("%s_b%0d", tag, i), {23'd0, obs},
             {23'd0, ref_byte(i, d, p, b, o)});
      end
   endtask

   task automatic pulse_update();
      @(negedge clk) update = 1'b1;
      @(negedge clk) update = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int max);
      int k = 0;
      while (!ready && k < max) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_timeout"}, {31'd0, k < max}, 32'd1);
   endtask

   task automatic wait_latches(input string tag, input int n);
      int k = 0;
      while (got.size() < n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_timeout"}, {31'd0, k < 2000}, 32'd1);
   endtask

   task automatic run_seq(input string tag);
      int base = got.size();
      int he = hold_err;
      logic [15:0] d = digits;
      logic [3:0]  p = dp;
      logic [2:0]  b = brightness;
      logic        o = display_on;
      pulse_update();
      wait_ready(tag, 3000);
      chk({tag, "_count"}, got.size() - base, 32'd7);
      check_seq(tag, base, d, p, b, o);
      chk({tag, "_hold"}, hold_err - he, 32'd0);
   endtask

   initial begin
      int base;
      logic [8:0] obs;

      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_latch", {31'd0, drv_latch}, 32'd0);
      chk("rst_byte", {23'd0, drv_stop, drv_byte}, 32'd0);
      rst = 1'b0;
      repeat (1000) @(negedge clk);
      chk("no_auto_refresh", got.size(), 32'd0);
      chk("idle_ready", {31'd0, ready}, 32'd1);

      digits = 16'h1234; dp = 4'h0; brightness = 3'd7; display_on = 1'b1;
      run_seq("seq_1234");
      digits = 16'h8888; dp = 4'b1000; brightness = 3'd2;
      run_seq("seq_8888");
      display_on = 1'b0; brightness = 3'd5;
      run_seq("seq_off");

      // Requests during a sequence coalesce into one extra sequence
      digits = 16'h1234; dp = 4'h0; brightness = 3'd7; display_on = 1'b1;
      base = got.size();
      pulse_update();
      wait_latches("pend_wait", base + 2);
      digits = 16'hABCD;
      pulse_update();
      repeat (10) @(negedge clk);
      pulse_update();
      wait_ready("pend", 6000);
      chk("pend_count", got.size() - base, 32'd14);
      check_seq("pend_first", base, 16'h1234, 4'h0, 3'd7, 1'b1);
      check_seq("pend_extra", base + 7, 16'hABCD, 4'h0, 3'd7, 1'b1);
      repeat (50) @(negedge clk);
      chk("pend_no_more", got.size() - base, 32'd14);

      // Reset while waiting on byte 3
      base = got.size();
      pulse_update();
      wait_latches("rst_mid_wait", base + 4);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready", {31'd0, ready}, 32'd1);
      chk("rst_mid_latch", {31'd0, drv_latch}, 32'd0);
      chk("rst_mid_byte", {23'd0, drv_stop, drv_byte}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_seq("after_rst");

      for (int n = 0; n < 6; n++) begin
         digits = 16'($urandom);
         dp = 4'($urandom);
         brightness = 3'($urandom);
         display_on = 1'($urandom);
         busy_len = $urandom_range(1, 25);
         run_seq($sformatf("rand%0d", n));
      end

      rst_r = 1'b0;
      repeat (700) @(negedge clk);
      chk("refresh_runs", {31'd0, runs.size() >= 3}, 32'd1);
      if (runs.size() >= 3) begin
         chk("refresh_gap1", runs[1], 32'd100);
         chk("refresh_gap2", runs[2], 32'd100);
      end
      chk("refresh_bytes", {31'd0, got_r.size() >= 14}, 32'd1);
      for (int i = 0; i < 14; i++) begin
         obs = (i < got_r.size()) ? got_r[i] : 9'h1FF;
         chk($sformatf("refresh_b%0d", i), {23'd0, obs},
             {23'd0, ref_byte(i % 7, 16'h0F5A, 4'b0101, 3'd3, 1'b1)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
